// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU: one bit per clock through a 1-bit slice, with the ripple carry held in a register.
// Latency: WIDTH+1 cycles from the accept edge to the done pulse (33 for WIDTH=32).
// Backpressure: start is ignored while busy; it is not queued and no error is raised.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, FIXUP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, shadow;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             carry_q, v_q, set_q;

  logic             is_sub, is_arith;
  logic             a_bit, b_bit, sum_bit, cry_bit, slice_bit;
  logic [WIDTH-1:0] res_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT until the MSB, one FIXUP cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (idx == LAST) state_nx = FIXUP;
      FIXUP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One ALU slice for the current bit position; B is inverted for SUB/SLT
  always_comb begin
    is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
    is_arith = is_sub || (op_q == OP_ADD);
    a_bit    = a_q[idx];
    b_bit    = b_q[idx] ^ is_sub;
    sum_bit  = a_bit ^ b_bit ^ carry_q;
    cry_bit  = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    case (op_q)
      OP_AND:  slice_bit = a_q[idx] & b_q[idx];
      OP_OR:   slice_bit = a_q[idx] | b_q[idx];
      default: slice_bit = sum_bit;
    endcase
  end

  // Word result selection at FIXUP; unsupported ops yield zero
  always_comb begin
    res_nx = '0;
    case (op_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB: res_nx = shadow;
      OP_SLT:  res_nx = {{(WIDTH-1){1'b0}}, set_q};
      default: res_nx = '0;
    endcase
  end

  // Datapath: operand latch, per-bit shadow/carry update, MSB flags, output writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      idx      <= '0;
      carry_q  <= 1'b0;
      v_q      <= 1'b0;
      set_q    <= 1'b0;
      shadow   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            idx     <= '0;
            carry_q <= (op == OP_SUB) || (op == OP_SLT);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          shadow[idx] <= slice_bit;
          carry_q     <= cry_bit;
          if (idx == LAST) begin
            // MSB slice: overflow is carry-in xor carry-out; set corrects the sign by it
            v_q   <= carry_q ^ cry_bit;
            set_q <= sum_bit ^ (carry_q ^ cry_bit);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        FIXUP: begin
          result   <= res_nx;
          zero     <= (res_nx == '0);
          c_out    <= is_arith ? carry_q : 1'b0;
          overflow <= is_arith ? v_q : 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: table of operations plus multi-cycle sequences.
// Latency: every operation is expected to finish 33 cycles after its accept edge.
// Backpressure: exercises start-while-busy, start during done, and reset mid-operation.
module tb_serial_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        busy, done, c_out, overflow, zero;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  serial_alu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result),
    .c_out(c_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive a request, let it be accepted at the next edge, then scramble the inputs
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
    a = ia; b = ib; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'b010;
  endtask

  // Count cycles from the accept edge to done; optionally poke start at cycle poke_at
  task automatic wait_done(input int poke_at, output int n, output logic busy_ok);
    int k = 0;
    busy_ok = 1'b1;
    while (!done && k < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      k++;
      start = 1'b0;
      if (k == poke_at) begin
        start = 1'b1; a = 32'd100; b = 32'd200; op = 3'b010;
      end
    end
    start = 1'b0;
    n = done ? k : 0;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] r,
                            input logic c, input logic v, input logic z);
    chk({tag, " result"},   result,         r);
    chk({tag, " c_out"},    32'(c_out),     32'(c));
    chk({tag, " overflow"}, 32'(overflow),  32'(v));
    chk({tag, " zero"},     32'(zero),      32'(z));
    chk({tag, " busy"},     32'(busy),      32'd0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int    n, cnt;
    logic  bok;
    string tag;

    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h00000003, 32'h00000005, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h12345678, 32'h9ABCDEF0, 3'b011, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'b101, 32'h00000000, 1'b0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst done", 32'(done), 32'd0);
    check_outs("rst", 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven operations
    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      issue(vecs[i].a, vecs[i].b, vecs[i].op);
      chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      wait_done(-1, n, bok);
      chk({tag, " latency"}, n, 32'd33);
      chk({tag, " busy_held"}, 32'(bok), 32'd1);
      check_outs(tag, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " result_held"}, result, vecs[i].res);
    end

    // start while busy is ignored and not queued
    issue(32'd1, 32'd2, 3'b010);
    wait_done(10, n, bok);
    chk("ignore latency", n, 32'd33);
    chk("ignore result", result, 32'd3);
    count_dones(40, cnt);
    chk("ignore no_second_done", cnt, 32'd0);
    chk("ignore result_held", result, 32'd3);

    // Back-to-back: start during the done cycle is accepted at that edge
    issue(32'h00000010, 32'h00000020, 3'b010);
    wait_done(-1, n, bok);
    chk("b2b first latency", n, 32'd33);
    chk("b2b first result", result, 32'h30);
    chk("b2b done_high", 32'(done), 32'd1);
    issue(32'd10, 32'd3, 3'b110);
    chk("b2b second busy", 32'(busy), 32'd1);
    wait_done(-1, n, bok);
    chk("b2b second latency", n, 32'd33);
    check_outs("b2b second", 32'd7, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an ADD discards it
    issue(32'h11111111, 32'h22222222, 3'b010);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst done", 32'(done), 32'd0);
    check_outs("midrst", 32'h0, 1'b0, 1'b0, 1'b1);
    count_dones(40, cnt);
    chk("midrst no_done", cnt, 32'd0);

    // Fresh operations after reset complete normally
    issue(32'h12345678, 32'h11111111, 3'b010);
    wait_done(-1, n, bok);
    chk("post latency", n, 32'd33);
    check_outs("post add", 32'h23456789, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    issue(32'hDEADBEEF, 32'h00000001, 3'b011);
    wait_done(-1, n, bok);
    chk("post unsup latency", n, 32'd33);
    check_outs("post unsup", 32'h0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
